// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: control encodings, size codes, FSM states
// and the default I/O region tag.
package load_store_unit_pkg;

   localparam logic        RstEnable    = 1'b1;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic        Hit          = 1'b1;
   localparam logic        Miss         = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

   localparam logic [1:0] SizeByte = 2'd0;
   localparam logic [1:0] SizeHalf = 2'd1;
   localparam logic [1:0] SizeWord = 2'd2;

   localparam logic [1:0] IoBaseHi = 2'b11;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StGnt  = 3'd1,
      StRd   = 3'd2,
      StWr   = 3'd3,
      StDone = 3'd4
   } lsu_state_e;

   // Illegal size code 3 is treated as a word access.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SizeByte: size_bytes = 3'd1;
         SizeHalf: size_bytes = 3'd2;
         default:  size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data formatter: picks the byte/half lane out of a word and zero- or sign-extends it.
module lsu_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word_i[7:0];
      unique case (offset_i)
         2'd0: lane_b = word_i[7:0];
         2'd1: lane_b = word_i[15:8];
         2'd2: lane_b = word_i[23:16];
         2'd3: lane_b = word_i[31:24];
         default: lane_b = word_i[7:0];
      endcase
      lane_h = offset_i[1] ? word_i[31:16] : word_i[15:0];

      unique case (size_i)
         SizeByte: data_o = {{24{signed_i & lane_b[7]}}, lane_b};
         SizeHalf: data_o = {{16{signed_i & lane_h[15]}}, lane_h};
         default:  data_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: dcache lookup, byte-serial RAM transactions on miss, I/O
// or store, and dcache fill/update on completion.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter logic [1:0] IO_BASE_HI = IoBaseHi
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_wdata_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic [31:0] dc_raddr_o,
   input  logic        dc_hit_i,
   input  logic [31:0] dc_data_i,
   output logic        dc_we_o,
   output logic [31:0] dc_waddr_o,
   output logic [31:0] dc_wdata_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_a_o,
   output logic        mem_wr_o,
   output logic [7:0]  mem_dout_o,
   input  logic [7:0]  mem_din_i
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] wdata_q, wdata_d;
   logic        hit_q, hit_d;
   logic        io_q, io_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  k_q, k_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req_io;
   logic [2:0]  n_bytes;
   logic [2:0]  m_bytes;
   logic [31:0] base;
   logic [1:0]  ext_off;
   logic [1:0]  ext_size;
   logic        ext_signed;
   logic [31:0] ext_data;
   logic [31:0] merged;
   logic        dc_write;

   assign req_io  = (req_addr_i[17:16] == IO_BASE_HI);
   assign n_bytes = size_bytes(size_q);
   // Cached loads always fetch the whole word so the fill is complete.
   assign m_bytes = io_q ? n_bytes : 3'd4;
   assign base    = (io_q || we_q) ? addr_q : {addr_q[31:2], 2'b00};

   // In IDLE the extender sees the live request so a hit completes without a RAM trip.
   always_comb begin
      if (state_q == StIdle) begin
         ext_off    = req_io ? 2'b00 : req_addr_i[1:0];
         ext_size   = req_size_i;
         ext_signed = req_signed_i;
      end else begin
         ext_off    = io_q ? 2'b00 : addr_q[1:0];
         ext_size   = size_q;
         ext_signed = signed_q;
      end
   end

   lsu_extend u_extend (
      .word_i   (word_d),
      .offset_i (ext_off),
      .size_i   (ext_size),
      .signed_i (ext_signed),
      .data_o   (ext_data)
   );

   // Byte k arrives while the counter reads k+1; it lands in lane k.
   always_comb begin
      word_d = word_q;
      if (state_q == StIdle && req_valid_i) begin
         word_d = dc_data_i;
      end else if (state_q == StRd) begin
         for (int i = 0; i < 4; i++) begin
            if (k_q == 3'(i + 1)) word_d[8*i +: 8] = mem_din_i;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      size_d     = size_q;
      signed_d   = signed_q;
      wdata_d    = wdata_q;
      hit_d      = hit_q;
      io_d       = io_q;
      k_d        = k_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      rdata_d    = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               we_d     = req_we_i;
               addr_d   = req_addr_i;
               size_d   = req_size_i;
               signed_d = req_signed_i;
               wdata_d  = req_wdata_i;
               hit_d    = dc_hit_i;
               io_d     = req_io;
               k_d      = 3'd0;
               if (!req_we_i && !req_io && dc_hit_i == Hit) begin
                  state_d = StDone;
                  rdata_d = ext_data;
               end else begin
                  state_d = StGnt;
               end
            end
         end
         StGnt: begin
            if (mem_gnt_i) begin
               k_d     = 3'd0;
               mem_a_d = base;
               if (we_q) begin
                  state_d    = StWr;
                  mem_dout_d = wdata_q[7:0];
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            if (k_q == m_bytes) begin
               state_d = StDone;
               rdata_d = ext_data;
            end else begin
               k_d = k_q + 3'd1;
               if ((k_q + 3'd1) < m_bytes) mem_a_d = mem_a_q + 32'd1;
            end
         end
         StWr: begin
            if (k_q == n_bytes - 3'd1) begin
               state_d = StDone;
            end else begin
               k_d     = k_q + 3'd1;
               mem_a_d = mem_a_q + 32'd1;
               for (int i = 0; i < 3; i++) begin
                  if (k_q == 3'(i)) mem_dout_d = wdata_q[8*(i+1) +: 8];
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Store bytes overlaid on the latched dcache word; a word store replaces it entirely.
   always_comb begin
      merged = word_q;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            if (i < int'(n_bytes) && j == int'(addr_q[1:0]) + i) begin
               merged[8*j +: 8] = wdata_q[8*i +: 8];
            end
         end
      end
   end

   // Partial stores never allocate; I/O never touches the dcache.
   assign dc_write = !io_q && (we_q ? (n_bytes == 3'd4 || hit_q == Hit) : (hit_q == Miss));

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         addr_q     <= ZeroWord;
         size_q     <= SizeByte;
         signed_q   <= 1'b0;
         wdata_q    <= ZeroWord;
         hit_q      <= Miss;
         io_q       <= 1'b0;
         word_q     <= ZeroWord;
         k_q        <= 3'd0;
         mem_a_q    <= ZeroWord;
         mem_dout_q <= 8'h00;
         rdata_q    <= ZeroWord;
      end else if (rdy) begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         wdata_q    <= wdata_d;
         hit_q      <= hit_d;
         io_q       <= io_d;
         word_q     <= word_d;
         k_q        <= k_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         rdata_q    <= rdata_d;
      end
   end

   assign done_o     = (state_q == StDone);
   assign rdata_o    = rdata_q;
   assign busy_o     = req_valid_i & ~done_o;
   assign dc_raddr_o = {req_addr_i[31:2], 2'b00};
   assign dc_we_o    = (state_q == StDone) && dc_write ? WriteEnable : WriteDisable;
   assign dc_waddr_o = {addr_q[31:2], 2'b00};
   assign dc_wdata_o = we_q ? merged : word_q;
   assign mem_req_o  = (state_q == StGnt) || (state_q == StRd) || (state_q == StWr);
   assign mem_a_o    = mem_a_q;
   assign mem_wr_o   = (state_q == StWr);
   assign mem_dout_o = mem_dout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-addressed RAM, dcache map and arbiter models,
// with expected results derived from the memory contents.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        req_valid_i;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [1:0]  req_size_i;
   logic        req_signed_i;
   logic [31:0] req_wdata_i;
   logic        done_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic [31:0] dc_raddr_o;
   logic        dc_hit_i;
   logic [31:0] dc_data_i;
   logic        dc_we_o;
   logic [31:0] dc_waddr_o;
   logic [31:0] dc_wdata_o;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic [31:0] mem_a_o;
   logic        mem_wr_o;
   logic [7:0]  mem_dout_o;
   logic [7:0]  mem_din_i;

   logic [7:0]  ram [0:262143];
   logic [31:0] cache [logic [31:0]];
   int          gnt_delay;
   int          gcnt;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .req_valid_i  (req_valid_i),
      .req_we_i     (req_we_i),
      .req_addr_i   (req_addr_i),
      .req_size_i   (req_size_i),
      .req_signed_i (req_signed_i),
      .req_wdata_i  (req_wdata_i),
      .done_o       (done_o),
      .rdata_o      (rdata_o),
      .busy_o       (busy_o),
      .dc_raddr_o   (dc_raddr_o),
      .dc_hit_i     (dc_hit_i),
      .dc_data_i    (dc_data_i),
      .dc_we_o      (dc_we_o),
      .dc_waddr_o   (dc_waddr_o),
      .dc_wdata_o   (dc_wdata_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_a_o      (mem_a_o),
      .mem_wr_o     (mem_wr_o),
      .mem_dout_o   (mem_dout_o),
      .mem_din_i    (mem_din_i)
   );

   // RAM with two-edge read latency, dcache storage, and a grant-after-delay arbiter.
   always @(posedge clk) begin
      if (rst) begin
         mem_gnt_i <= 1'b0;
         gcnt      <= 0;
      end else if (rdy) begin
         mem_din_i <= ram[mem_a_o[17:0]];
         if (mem_wr_o) ram[mem_a_o[17:0]] = mem_dout_o;
         if (dc_we_o) cache[dc_waddr_o] = dc_wdata_o;
         if (!mem_req_o) begin
            mem_gnt_i <= 1'b0;
            gcnt      <= 0;
         end else if (gcnt >= gnt_delay) begin
            mem_gnt_i <= 1'b1;
         end else begin
            gcnt <= gcnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [7:0] rd_ram(input logic [31:0] a);
      return ram[a[17:0]];
   endfunction

   function automatic logic [31:0] ref_extend(input logic [31:0] raw, input int n,
                                              input logic sgn);
      if (n == 1) return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      if (n == 2) return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      return raw;
   endfunction

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input int gd);
      int          n, m, exp_lat, lat, wr_cnt, dcw_cnt, exp_dcw;
      logic        io, hit, got, req_seen, early;
      logic [31:0] aligned, raw, exp_word, rd, a0;
      logic [7:0]  b;
      n       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      io      = (addr[17:16] == 2'b11);
      aligned = {addr[31:2], 2'b00};
      hit     = !io && cache.exists(aligned);
      m       = io ? n : 4;
      raw     = 32'h0;
      for (int i = 0; i < n; i++) raw[8*i +: 8] = rd_ram(addr + 32'(i));
      exp_word = 32'h0;
      for (int j = 0; j < 4; j++) begin
         b = rd_ram(aligned + 32'(j));
         if (we) for (int i = 0; i < n; i++)
            if (addr + 32'(i) == aligned + 32'(j)) b = wdata[8*i +: 8];
         exp_word[8*j +: 8] = b;
      end
      exp_dcw = (!io && (we ? (n == 4 || hit) : !hit)) ? 1 : 0;
      if (!we && hit) exp_lat = 1;
      else if (!we)   exp_lat = 1 + (gd + 2) + m + 1;
      else            exp_lat = 1 + (gd + 2) + n;

      gnt_delay    = gd;
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_addr_i   = addr;
      req_size_i   = size;
      req_signed_i = sgn;
      req_wdata_i  = wdata;
      dc_hit_i     = io ? 1'b1 : hit;
      dc_data_i    = (hit && !io) ? cache[aligned] : $urandom;
      a0 = mem_a_o;
      wr_cnt = 0; dcw_cnt = 0; lat = 0; got = 1'b0; req_seen = 1'b0; early = 1'b0;
      rd = 32'h0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (mem_wr_o && wr_cnt < 4) begin
            check("wr_addr", mem_a_o, addr + 32'(wr_cnt));
            check("wr_data", {24'h0, mem_dout_o}, {24'h0, wdata[8*wr_cnt +: 8]});
         end
         if (mem_wr_o) wr_cnt++;
         if (mem_req_o) req_seen = 1'b1;
         if (!mem_gnt_i && mem_a_o != a0) early = 1'b1;
         if (dc_we_o) begin
            dcw_cnt++;
            check("dc_waddr", dc_waddr_o, aligned);
            check("dc_wdata", dc_wdata_o, exp_word);
         end
         if (done_o) begin
            lat = c;
            rd  = rdata_o;
            got = 1'b1;
            break;
         end
      end
      req_valid_i = 1'b0;
      check("done_seen", {31'h0, got}, 32'h1);
      check("latency", lat, exp_lat);
      if (!we) check("rdata", rd, ref_extend(raw, n, sgn));
      check("wr_count", wr_cnt, we ? n : 0);
      check("dc_we_count", dcw_cnt, exp_dcw);
      check("addr_before_gnt", {31'h0, early}, 32'h0);
      if (!we && hit) check("hit_no_req", {31'h0, req_seen}, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      int          dcw;
      int          c;
      logic [31:0] a, exp_rd;
      logic [1:0]  sz;
      rst = 1'b1; rdy = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0;
      req_size_i = 2'd0; req_signed_i = 1'b0; req_wdata_i = 32'h0; dc_hit_i = 1'b0;
      dc_data_i = 32'h0; gnt_delay = 0; mem_din_i = 8'h00;
      for (int i = 0; i < 262144; i++) ram[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check("rst_done", {31'h0, done_o}, 32'h0);
      check("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
      check("rst_mem_wr", {31'h0, mem_wr_o}, 32'h0);
      check("rst_dc_we", {31'h0, dc_we_o}, 32'h0);
      check("rst_mem_a", mem_a_o, 32'h0);
      check("rst_dout", {24'h0, mem_dout_o}, 32'h0);
      check("rst_rdata", rdata_o, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      do_req(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 1);
      check("t1_cache", cache[32'h100], 32'hDEADBEEF);
      do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0);
      ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h80;
      cache.delete(32'h200);
      do_req(1'b0, 32'h203, 2'd0, 1'b1, 32'h0, 2);
      check("t3_fill", cache[32'h200], 32'h80332211);
      do_req(1'b1, 32'h101, 2'd0, 1'b0, 32'h55, 0);
      check("t4_merge", cache[32'h100], 32'hDEAD55EF);
      do_req(1'b0, 32'h30004, 2'd2, 1'b0, 32'h0, 1);
      do_req(1'b1, 32'h30000, 2'd0, 1'b0, 32'hA5, 0);
      cache.delete(32'h40);
      do_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 4);

      // Frozen completion: done_o must hold while rdy is low, then drop.
      exp_rd = cache[32'h100];
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h100; req_size_i = 2'd2;
      dc_hit_i = 1'b1; dc_data_i = exp_rd;
      @(negedge clk);
      check("rdy_done", {31'h0, done_o}, 32'h1);
      rdy = 1'b0; req_valid_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rdy_hold_done", {31'h0, done_o}, 32'h1);
         check("rdy_hold_rdata", rdata_o, exp_rd);
      end
      rdy = 1'b1;
      @(negedge clk);
      check("rdy_release", {31'h0, done_o}, 32'h0);
      @(negedge clk);

      // Reset during the read phase must abort cleanly.
      cache.delete(32'h2C0);
      gnt_delay = 0; dcw = 0; c = 0;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h2C0; req_size_i = 2'd2;
      dc_hit_i = 1'b0; dc_data_i = 32'h0;
      while (!mem_gnt_i && c < 20) begin
         @(negedge clk);
         c++;
         if (dc_we_o) dcw++;
      end
      check("rst_gnt", {31'h0, mem_gnt_i}, 32'h1);
      repeat (3) begin
         @(negedge clk);
         if (dc_we_o) dcw++;
      end
      check("rst_in_rd", {31'h0, mem_req_o}, 32'h1);
      rst = 1'b1; req_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_done", {31'h0, done_o}, 32'h0);
      check("abort_req", {31'h0, mem_req_o}, 32'h0);
      check("abort_mem_a", mem_a_o, 32'h0);
      check("abort_rdata", rdata_o, 32'h0);
      check("abort_busy", {31'h0, busy_o}, 32'h0);
      repeat (3) begin
         if (dc_we_o) dcw++;
         @(negedge clk);
      end
      check("abort_no_dc_we", dcw, 0);
      check("abort_no_fill", {31'h0, cache.exists(32'h2C0)}, 32'h0);

      for (int t = 0; t < 200; t++) begin
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) a = 32'h30000 | 32'($urandom_range(0, 255));
         else a = 32'($urandom_range(0, 255));
         if (sz == 2'd1) a = a & ~32'h1;
         else if (sz != 2'd0) a = a & ~32'h3;
         do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
